// File: rtl/bidir_shift_ctrl.sv
// Command sequencer for a bidirectional shift register: optional clear, serial load
// of a parallel word in either direction, then return of the register contents.
module bidir_shift_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             cmd_clr,
    output logic             sr_rst,
    output logic             sr_en,
    output logic             sr_dir,
    output logic             sr_din,
    input  logic [WIDTH-1:0] sr_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LenMax = CNT_W'(WIDTH);

    typedef enum logic [2:0] {StIdle, StClr, StShift, StSettle, StResp} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sr_rst_q, sr_rst_d;
    logic               sr_en_q, sr_en_d;
    logic               sr_dir_q, sr_dir_d;
    logic               sr_din_q, sr_din_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   len_eff;
    logic               start_shift;
    logic               drive_bit;

    assign len_eff = (cmd_len == '0 || cmd_len > LenMax) ? LenMax : cmd_len;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dir_d       = dir_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        sr_rst_d    = 1'b0;
        sr_en_d     = 1'b0;
        sr_dir_d    = sr_dir_q;
        sr_din_d    = sr_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        start_shift = 1'b0;
        drive_bit   = 1'b0;

        // Outputs are computed for the state being entered, so they line up with it.
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    data_d = cmd_data;
                    dir_d  = cmd_dir;
                    len_d  = len_eff;
                    if (cmd_clr) begin
                        state_d  = StClr;
                        sr_rst_d = 1'b1;
                    end else begin
                        state_d     = StShift;
                        start_shift = 1'b1;
                    end
                end
            end
            StClr: begin
                state_d     = StShift;
                start_shift = 1'b1;
            end
            StShift: begin
                if (cnt_q == '0) begin
                    state_d = StSettle;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    idx_d     = dir_q ? idx_q + CNT_W'(1) : idx_q - CNT_W'(1);
                    sr_en_d   = 1'b1;
                    drive_bit = 1'b1;
                end
            end
            StSettle: begin
                rsp_data_d  = sr_out;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_shift) begin
            sr_en_d   = 1'b1;
            sr_dir_d  = dir_d;
            idx_d     = dir_d ? (LenMax - len_d) : (len_d - CNT_W'(1));
            cnt_d     = len_d - CNT_W'(1);
            drive_bit = 1'b1;
        end

        if (drive_bit) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (idx_d == CNT_W'(i)) sr_din_d = data_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            dir_q       <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            sr_rst_q    <= 1'b0;
            sr_en_q     <= 1'b0;
            sr_dir_q    <= 1'b0;
            sr_din_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sr_rst_q    <= sr_rst_d;
            sr_en_q     <= sr_en_d;
            sr_dir_q    <= sr_dir_d;
            sr_din_q    <= sr_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign sr_rst    = sr_rst_q;
    assign sr_en     = sr_en_q;
    assign sr_dir    = sr_dir_q;
    assign sr_din    = sr_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bidir_shift_ctrl.sv
// Directed bench for bidir_shift_ctrl with a behavioural 4-bit shift register attached.
module tb_bidir_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_data = '0;
    logic       cmd_dir = 1'b0;
    logic [2:0] cmd_len = '0;
    logic       cmd_clr = 1'b0;
    logic       sr_rst, sr_en, sr_dir, sr_din;
    logic [3:0] sr_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    bidir_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_clr   (cmd_clr),
        .sr_rst    (sr_rst),
        .sr_en     (sr_en),
        .sr_dir    (sr_dir),
        .sr_din    (sr_din),
        .sr_out    (sr_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Shift register being controlled
    logic [3:0] sr_q = '0;
    always @(posedge clk) begin
        if (sr_rst)     sr_q <= '0;
        else if (sr_en) sr_q <= sr_dir ? {sr_din, sr_q[3:1]} : {sr_q[2:0], sr_din};
    end
    assign sr_out = sr_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [3:0] data, input logic dir, input logic [2:0] len,
                            input logic clr, input string tag);
        @(negedge clk);
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_len   = len;
        cmd_clr   = clr;
        cmd_valid = 1'b1;
        check_eq({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
    endtask

    // Called just after the accepting edge, which counts as edge 1.
    task automatic wait_rsp(input string tag, input int exp_lat, input int exp_n,
                            input logic [3:0] exp_seq, input int exp_rst,
                            input logic [3:0] exp_data);
        int         n = 0;
        int         lat = 0;
        int         shifts = 0;
        int         rsts = 0;
        logic [3:0] seq = '0;
        bit         got = 1'b0;
        bit         overlap = 1'b0;
        while (!got && n < 20) begin
            n++;
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
                lat = n;
            end else begin
                if (sr_en) begin
                    seq = {seq[2:0], sr_din};
                    shifts++;
                end
                if (sr_rst) rsts++;
                if (sr_en && sr_rst) overlap = 1'b1;
            end
        end
        check_eq({tag, " rsp_timeout"}, 32'(got), 32'd1);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " shifts"}, 32'(shifts), 32'(exp_n));
        check_eq({tag, " din_seq"}, 32'(seq), 32'(exp_seq));
        check_eq({tag, " clr_pulses"}, 32'(rsts), 32'(exp_rst));
        check_eq({tag, " en_rst_overlap"}, 32'(overlap), 32'd0);
        check_eq({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    endtask

    task automatic take_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, " rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, " idle"}, 32'({cmd_ready, busy}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset sr_pins", 32'({sr_rst, sr_en, sr_dir, sr_din}), 32'd0);
        check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b1;

        send_cmd(4'b1011, 1'b0, 3'd4, 1'b1, "full_left");
        wait_rsp("full_left", 7, 4, 4'b1011, 1, 4'b1011);
        take_rsp("full_left");

        send_cmd(4'b1011, 1'b1, 3'd0, 1'b1, "full_right");
        wait_rsp("full_right", 7, 4, 4'b1101, 1, 4'b1011);
        check_eq("full_right dir_held", 32'(sr_dir), 32'd1);
        take_rsp("full_right");

        send_cmd(4'b1011, 1'b0, 3'd2, 1'b1, "part_left");
        wait_rsp("part_left", 5, 2, 4'b0011, 1, 4'b0011);
        take_rsp("part_left");

        send_cmd(4'b1011, 1'b1, 3'd2, 1'b1, "part_right");
        wait_rsp("part_right", 5, 2, 4'b0001, 1, 4'b1000);
        take_rsp("part_right");

        // Register holds 1000; one right shift keeps prior bits moved down.
        send_cmd(4'b1000, 1'b1, 3'd1, 1'b0, "keep_right");
        wait_rsp("keep_right", 3, 1, 4'b0001, 0, 4'b1100);
        take_rsp("keep_right");

        send_cmd(4'b0110, 1'b0, 3'd7, 1'b0, "len_over");
        wait_rsp("len_over", 6, 4, 4'b0110, 0, 4'b0110);
        take_rsp("len_over");

        send_cmd(4'b1011, 1'b0, 3'd4, 1'b1, "bp_first");
        wait_rsp("bp_first", 7, 4, 4'b1011, 1, 4'b1011);
        cmd_data  = 4'b0101;
        cmd_dir   = 1'b0;
        cmd_len   = 3'd4;
        cmd_clr   = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp rsp_data_stable", 32'(rsp_data), 32'b1011);
            check_eq("bp hold", 32'({rsp_valid, cmd_ready}), 32'b10);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("bp no_bypass", 32'({rsp_valid, cmd_ready}), 32'b01);
        @(posedge clk);
        wait_rsp("bp_second", 6, 4, 4'b0101, 0, 4'b0101);
        take_rsp("bp_second");

        send_cmd(4'b1111, 1'b0, 3'd4, 1'b0, "mid_rst");
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst shifting", 32'({busy, sr_en}), 32'b11);
        rst = 1'b0;
        #1;
        check_eq("mid_rst sr_en", 32'(sr_en), 32'd0);
        check_eq("mid_rst idle", 32'({cmd_ready, busy}), 32'b10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (rsp_valid || busy) seen = 1'b1;
            end
            check_eq("mid_rst no_rsp", 32'(seen), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bidir_shift_ctrl.md
Name: bidir_shift_ctrl

Overview:
Command sequencer for the team's 4-bit bidirectional shift register. It accepts a parallel word, a direction and a shift length over a valid/ready handshake, and can optionally clear the register first. It then drives the register's en/dir/din pins to serialize the word in, and returns the resulting parallel contents on a valid/ready response channel. It sits between a host/CSR master and one shift-register instance; it is the sole driver of that instance's control pins.

Parameters:
WIDTH, 4, shift-register width in bits
CNT_W, 3, counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command
cmd_data  input  WIDTH  word to serialize
cmd_dir  input  1  0 = shift left (din enters LSB), 1 = shift right (din enters MSB)
cmd_len  input  CNT_W  shifts to perform, 1..WIDTH; 0 or >WIDTH treated as WIDTH
cmd_clr  input  1  clear the shift register before shifting
sr_rst  output  1  active-high clear pulse to the shift register (synchronous at the register)
sr_en  output  1  shift enable to the shift register
sr_dir  output  1  direction to the shift register
sr_din  output  1  serial data to the shift register
sr_out  input  WIDTH  shift-register parallel output
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_data  output  WIDTH  captured sr_out
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, sr_rst=0, sr_en=0, sr_dir=0, sr_din=0, rsp_valid=0, rsp_data=0, busy=0. All sr_* and rsp_* outputs are registered.
- States: IDLE, CLR, SHIFT, SETTLE, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch data/dir/len/clr. Go to CLR if cmd_clr=1, otherwise go to SHIFT.
- CLR: exactly 1 cycle with sr_rst=1 and sr_en=0, then go to SHIFT.
- SHIFT: exactly len cycles with sr_en=1, sr_dir=dir_q, and sr_din = data_q[idx].
  - dir=0: idx starts at len-1 and decrements, so sr_out[len-1:0] ends equal to data[len-1:0].
  - dir=1: idx starts at WIDTH-len and increments, so sr_out[WIDTH-1:WIDTH-len] ends equal to data[WIDTH-1:WIDTH-len].
  - Unshifted positions keep their prior contents shifted by len.
- SETTLE: 1 cycle with sr_en=0. At the end of this cycle sr_out is captured into rsp_data.
- RESP: rsp_valid=1 with rsp_data stable until rsp_ready=1. On that edge rsp_valid drops and the state goes to IDLE.
- Latency, measured from the cmd handshake edge: rsp_valid rises at edge len+2, or len+3 with clr.
- cmd_ready=0 outside IDLE. Commands offered while busy are not accepted and not lost; the source holds them.
- There is no bypass: when an rsp handshake and a waiting cmd_valid coincide, the new command is accepted one cycle later, in IDLE.
- sr_en is never high in the same cycle as sr_rst.
- sr_dir and sr_din are held at their last values outside SHIFT; only sr_en gates the register.
- Reset asserted mid-operation returns the controller to IDLE immediately, with all outputs at reset values. A partial shift is abandoned and no response is produced.

Test Plan:
- Reset: hold rst=0 over 3 edges -> cmd_ready=1, busy=0, sr_en=0, rsp_valid=0, rsp_data=0.
- Full load, left: cmd_data=4'b1011, dir=0, len=4, clr=1 -> one sr_rst pulse, then 4 cycles of sr_en with sr_din=1,0,1,1; rsp_valid rises at edge 7; rsp_data=4'b1011.
- Full load, right: cmd_data=4'b1011, dir=1, len=0 (treated as 4), clr=1 -> sr_din=1,1,0,1; rsp_data=4'b1011.
- Partial, both directions, from a cleared register:
  - data=4'b1011, dir=0, len=2 -> rsp_data=4'b0011.
  - data=4'b1011, dir=1, len=2 -> rsp_data=4'b1000.
- Backpressure and overlap: hold rsp_ready=0 for 5 cycles with a second cmd_valid held high -> rsp_data stable and cmd_ready=0 throughout; after the rsp handshake the second command is accepted on the following edge.
- Mid-shift reset: assert rst=0 during the 2nd SHIFT cycle -> sr_en=0 and state IDLE immediately; no rsp_valid after reset releases.
